// File: rtl/miriscv_lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes,
// FSM state encoding, error cause codes and a size legality helper.
// Imported by the LSU top and its alignment helper.
package miriscv_lsu_pkg;

  // funct3 access sizes carried by load/store instructions
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  // LSU control states (2-bit encoding)
  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // error cause codes reported alongside lsu_err_o
  localparam logic [1:0] LSU_ERR_MISALIGN = 2'd0;
  localparam logic [1:0] LSU_ERR_BADSIZE  = 2'd1;
  localparam logic [1:0] LSU_ERR_TIMEOUT  = 2'd2;

  // funct3 codes 3, 6 and 7 have no load/store meaning
  function automatic logic is_bad_size(input logic [2:0] size);
    return (size == 3'd3) || (size == 3'd6) || (size == 3'd7);
  endfunction

endpackage

// File: rtl/miriscv_lsu_if.sv
// Data-bus interface between the LSU and the memory side.
// The request phase is held until granted; the response is a single rvalid pulse.
// The master drives req/we/be/addr/wdata, the slave drives gnt/rvalid/rdata.
interface miriscv_lsu_if;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/miriscv_lsu_align.sv
// Byte-lane steering: byte enables, replicated store data, alignment/size checks, load extension.
// Purely combinational, zero latency.
// No handshake; the caller decides when the outputs are used.
module miriscv_lsu_align
  import miriscv_lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata_raw,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign,
  output logic        badsize,
  output logic [31:0] ldata
);

  // Only the low halfword of the shifted read word is ever needed below a full word.
  logic [15:0] lane;

  assign lane    = 16'(rdata >> {addr_lo, 3'b000});
  assign badsize = is_bad_size(size);

  // Lane selection, alignment check and load extension per access width
  always_comb begin
    be       = 4'b0000;
    wdata    = 32'h0;
    misalign = 1'b0;
    ldata    = 32'h0;
    case (size)
      LDST_B, LDST_BU: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{wdata_raw[7:0]}};
        ldata = (size == LDST_B) ? {{24{lane[7]}}, lane[7:0]} : {24'h0, lane[7:0]};
      end
      LDST_H, LDST_HU: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{wdata_raw[15:0]}};
        misalign = addr_lo[0];
        ldata    = (size == LDST_H) ? {{16{lane[15]}}, lane} : {16'h0, lane};
      end
      LDST_W: begin
        be       = 4'b1111;
        wdata    = wdata_raw;
        misalign = |addr_lo;
        ldata    = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/miriscv_lsu.sv
// Load/store unit: one data-bus transaction per memory instruction, core stalled until done.
// Latency: aligned access needs IDLE+REQ(+RESP) stall cycles, result in DONE; errors stall 1 cycle.
// Backpressure: data_req held until gnt; REQ+RESP bounded by TIMEOUT cycles, then aborted.
module miriscv_lsu
  import miriscv_lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         lsu_req_i,
  input  logic         lsu_we_i,
  input  logic [2:0]   lsu_size_i,
  input  logic [31:0]  lsu_addr_i,
  input  logic [31:0]  lsu_data_i,
  output logic         lsu_stall_req_o,
  output logic [31:0]  lsu_data_o,
  output logic         lsu_err_o,
  output logic [1:0]   lsu_err_cause_o,
  miriscv_lsu_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e  state_q, state_d;
  logic        we_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q, err_d;
  logic [1:0]  cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q;
  logic        latch_en;
  logic        rdata_en;
  logic        timeout_hit;

  logic [2:0]  sel_size;
  logic [1:0]  sel_addr_lo;
  logic [3:0]  be_a;
  logic [31:0] wdata_a;
  logic        misalign_a;
  logic        badsize_a;
  logic [31:0] ldata_a;

  logic in_req;
  logic in_done;

  // In IDLE the checks must see the incoming op; afterwards everything runs off the latches.
  assign sel_size    = (state_q == LSU_IDLE) ? lsu_size_i      : size_q;
  assign sel_addr_lo = (state_q == LSU_IDLE) ? lsu_addr_i[1:0] : addr_q[1:0];

  miriscv_lsu_align u_align (
    .size      (sel_size),
    .addr_lo   (sel_addr_lo),
    .wdata_raw (wdata_q),
    .rdata     (rdata_q),
    .be        (be_a),
    .wdata     (wdata_a),
    .misalign  (misalign_a),
    .badsize   (badsize_a),
    .ldata     (ldata_a)
  );

  // The last permitted REQ/RESP cycle; a response arriving in it still completes normally.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= LSU_IDLE;
    else          state_q <= state_d;
  end

  // Request latches, captured read word and latched error status
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cause_q <= 2'd0;
    end else begin
      if (latch_en) begin
        we_q    <= lsu_we_i;
        size_q  <= lsu_size_i;
        addr_q  <= lsu_addr_i;
        wdata_q <= lsu_data_i;
      end
      if (rdata_en) rdata_q <= bus.data_rdata;
      err_q   <= err_d;
      cause_q <= cause_d;
    end
  end

  // Bus-phase cycle counter: held at zero in IDLE, counts every REQ and RESP cycle
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)                                        cnt_q <= '0;
    else if (state_q == LSU_IDLE)                        cnt_q <= '0;
    else if (state_q == LSU_REQ || state_q == LSU_RESP)  cnt_q <= cnt_q + CNT_W'(1);
  end

  // Next-state logic: request acceptance, bus handshake and abort paths
  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    rdata_en = 1'b0;
    err_d    = err_q;
    cause_d  = cause_q;
    case (state_q)
      LSU_IDLE: begin
        err_d   = 1'b0;
        cause_d = 2'd0;
        if (lsu_req_i) begin
          latch_en = 1'b1;
          if (badsize_a) begin
            state_d = LSU_DONE;
            err_d   = 1'b1;
            cause_d = LSU_ERR_BADSIZE;
          end else if (misalign_a) begin
            state_d = LSU_DONE;
            err_d   = 1'b1;
            cause_d = LSU_ERR_MISALIGN;
          end else begin
            state_d = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        // rvalid without gnt belongs to nothing we issued, so it is not looked at here
        if (bus.data_gnt && bus.data_rvalid) begin
          rdata_en = 1'b1;
          state_d  = LSU_DONE;
        end else if (timeout_hit) begin
          state_d = LSU_DONE;
          err_d   = 1'b1;
          cause_d = LSU_ERR_TIMEOUT;
        end else if (bus.data_gnt) begin
          state_d = LSU_RESP;
        end
      end
      LSU_RESP: begin
        if (bus.data_rvalid) begin
          rdata_en = 1'b1;
          state_d  = LSU_DONE;
        end else if (timeout_hit) begin
          state_d = LSU_DONE;
          err_d   = 1'b1;
          cause_d = LSU_ERR_TIMEOUT;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  assign in_req  = (state_q == LSU_REQ);
  assign in_done = (state_q == LSU_DONE);

  // Bus fields are only meaningful while requesting; keep them quiet otherwise.
  assign bus.data_req   = in_req;
  assign bus.data_we    = in_req & we_q;
  assign bus.data_be    = in_req ? be_a : 4'b0000;
  assign bus.data_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.data_wdata = in_req ? wdata_a : 32'h0;

  assign lsu_stall_req_o = lsu_req_i && (state_q != LSU_DONE);
  assign lsu_err_o       = in_done & err_q;
  assign lsu_err_cause_o = in_done ? cause_q : 2'd0;
  // Stores and any failed op return zero
  assign lsu_data_o      = (in_done && !err_q && !we_q) ? ldata_a : 32'h0;

endmodule
